dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Sequencer for the DDS phase accumulator: drives its phinc input to produce
//  programmable linear frequency sweeps (single, repeating sawtooth, triangle).
//  Sits between the control/config logic and the phase accumulator.
//  Pulses acc_clr so the accumulator restarts phase at each sweep start.
// PARAMETERS
//  INC_W    8   width of phase increment (must match accumulator phinc)
//  DWELL_W  12  width of dwell counter (cycles per frequency step - 1)
// PORTS
//  clk        in   1        clock
//  clrn       in   1        reset, asynchronous, active-low
//  start      in   1        1-cycle start request (honoured only when idle)
//  abort      in   1        stop immediately, return to idle
//  cfg_start  in   INC_W    first phase increment of the sweep
//  cfg_stop   in   INC_W    end-point phase increment
//  cfg_step   in   INC_W    increment change per step (0 treated as 1)
//  cfg_dwell  in   DWELL_W  each phinc value held cfg_dwell+1 cycles
//  cfg_mode   in   2        00 single, 01 repeat sawtooth, 10 triangle, 11 = single
//  phinc      out  INC_W    to accumulator phinc
//  acc_clr    out  1        1-cycle sync clear request to accumulator
//  busy       out  1        sweep in progress
//  done       out  1        1-cycle pulse at normal end of single sweep
//  dir        out  1        0 = leg toward cfg_stop, 1 = leg toward cfg_start
// BEHAVIOUR
//  - Reset: state IDLE; phinc=0, acc_clr=0, busy=0, done=0, dir=0, all regs 0.
//  - States: IDLE, FWD (toward stop), REV (toward start), FIN (1 cycle).
//  - IDLE: phinc=0. start sampled high -> latch all cfg_*, phinc<=cfg_start,
//    acc_clr=1 for that next cycle only, busy=1, dir=0, dwell counter loaded,
//    -> FWD. Registered outputs: latency 1 cycle from start sample.
//  - cfg_* changes while busy are ignored (latched copies used).
//  - Each phinc value held exactly cfg_dwell+1 cycles (dwell=0 -> new value
//    every cycle).
//  - Step arithmetic in INC_W+1 bits; direction per leg from compare of current
//    value vs target: target above -> add step, below -> subtract.
//    Result clamped to target if it passes it or over/underflows; no wrap.
//  - start==stop: first value is end-point; held one dwell, then end action.
//  - FWD end-point reached and its dwell expired:
//    single -> FIN; repeat -> phinc<=cfg_start (no acc_clr), stay FWD;
//    triangle -> REV, dir=1, first step away from stop.
//  - REV at cfg_start with dwell expired -> FWD, dir=0 (triangle runs until abort).
//  - FIN: phinc=0, done=1 one cycle, busy=0, -> IDLE.
//  - abort sampled high in any non-IDLE state: next cycle IDLE, phinc=0, busy=0,
//    dir=0, done stays 0. abort+start same cycle in IDLE: abort wins, no sweep.
//  - start while busy ignored. clrn low mid-sweep: immediate reset values.
// STRUCTURE
//  - dds_pkg: state encoding, mode codes (MODE_SINGLE/REPEAT/TRI), INC_W default.
//  - Sub-module dds_dwell_timer: load/decrement/expire pulse, DWELL_W wide.
//  - Top: FSM, latched cfg regs, clamp-step datapath, output regs.
// TESTING
//  1 single: start=10 stop=40 step=10 dwell=2 -> phinc 10,20,30,40 each 3
//    cycles (12 cycles), acc_clr with first 10, then phinc=0, done 1 cycle.
//  2 clamp: start=10 stop=35 step=10 dwell=0 single -> 10,20,30,35,0; done.
//  3 triangle descending: start=100 stop=80 step=8 dwell=0 -> 100,92,84,80,
//    88,96,100,92...; dir 0 on 100..80, 1 on 88..100; no done.
//  4 saturation: start=250 stop=255 step=10 single -> 250,255,0; never wraps;
//    step=0 with start=3 stop=5 -> 3,4,5.
//  5 control: abort during 20 in test1 -> next cycle phinc=0, busy=0, done=0;
//    start while busy ignored; start+abort together in IDLE -> stays IDLE.
//  6 reset: clrn low mid repeat sweep -> outputs 0 asynchronously; after
//    release stays IDLE until new start.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding, sweep mode codes and default widths for the DDS sweep sequencer.
package dds_pkg;
    typedef enum logic [1:0] {IDLE, FWD, REV, FIN} state_t;
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam int INC_W_DEF = 8;
endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: holds each frequency step; expired is high on the last cycle of a dwell.
module dds_dwell_timer #(
    parameter int DWELL_W = 12
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               load,
    input  logic [DWELL_W-1:0] val,
    output logic               expired
);
    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) cnt <= '0;
        else if (load) cnt <= val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign expired = cnt == '0;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the accumulator phase increment through single, sawtooth or triangle sweeps.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int INC_W   = INC_W_DEF,
    parameter int DWELL_W = 12
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               start,
    input  logic               abort,
    input  logic [INC_W-1:0]   cfg_start,
    input  logic [INC_W-1:0]   cfg_stop,
    input  logic [INC_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [INC_W-1:0]   phinc,
    output logic               acc_clr,
    output logic               busy,
    output logic               done,
    output logic               dir
);
    state_t state, state_n;
    logic [INC_W-1:0] start_l, stop_l, step_l, phinc_n, nxt_fwd, nxt_rev;
    logic [DWELL_W-1:0] dwell_l;
    logic [1:0] mode_l;
    logic acc_clr_n, busy_n, done_n, dir_n, load, expired, accept;

    // One step from cur toward tgt in INC_W+1 bits, clamped at tgt so it never overshoots or wraps.
    function automatic logic [INC_W-1:0] step_to(input logic [INC_W-1:0] cur, tgt, stp);
        logic [INC_W:0] s, d;
        s = {1'b0, cur} + {1'b0, stp};
        d = {1'b0, cur} - {1'b0, stp};
        return tgt > cur ? (s > {1'b0, tgt} ? tgt : s[INC_W-1:0])
                         : ((d[INC_W] || d[INC_W-1:0] < tgt) ? tgt : d[INC_W-1:0]);
    endfunction

    assign nxt_fwd = step_to(phinc, stop_l, step_l);
    assign nxt_rev = step_to(phinc, start_l, step_l);
    assign accept  = state == IDLE && start && !abort;

    dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
        .clk     (clk),
        .clrn    (clrn),
        .load    (load),
        .val     (state == IDLE ? cfg_dwell : dwell_l),
        .expired (expired)
    );

    always_comb begin
        state_n   = state;
        phinc_n   = phinc;
        acc_clr_n = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        dir_n     = dir;
        load      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n   = FWD;
                phinc_n   = cfg_start;
                acc_clr_n = 1'b1;
                busy_n    = 1'b1;
                dir_n     = 1'b0;
                load      = 1'b1;
            end
            FWD: if (expired) begin
                load = 1'b1;
                if (phinc != stop_l) phinc_n = nxt_fwd;
                else if (mode_l == MODE_REPEAT) phinc_n = start_l;
                else if (mode_l == MODE_TRI) begin
                    state_n = REV;
                    dir_n   = 1'b1;
                    phinc_n = nxt_rev;
                end else begin
                    state_n = FIN;
                    phinc_n = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    load    = 1'b0;
                end
            end
            REV: if (expired) begin
                load = 1'b1;
                if (phinc == start_l) begin
                    state_n = FWD;
                    dir_n   = 1'b0;
                    phinc_n = nxt_fwd;
                end else phinc_n = nxt_rev;
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            phinc_n = '0;
            busy_n  = 1'b0;
            dir_n   = 1'b0;
            done_n  = 1'b0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            phinc   <= '0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dir     <= 1'b0;
            start_l <= '0;
            stop_l  <= '0;
            step_l  <= '0;
            dwell_l <= '0;
            mode_l  <= '0;
        end else begin
            state   <= state_n;
            phinc   <= phinc_n;
            acc_clr <= acc_clr_n;
            busy    <= busy_n;
            done    <= done_n;
            dir     <= dir_n;
            if (accept) begin
                start_l <= cfg_start;
                stop_l  <= cfg_stop;
                step_l  <= cfg_step == '0 ? INC_W'(1) : cfg_step;
                dwell_l <= cfg_dwell;
                mode_l  <= cfg_mode;
            end
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed and random sweeps checked against a leg-list model of the sweep rules.
module tb_dds_sweep_ctrl;
    logic clk = 1'b0, clrn = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
    logic [11:0] cfg_dwell = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] phinc;
    logic acc_clr, busy, done, dir;
    int n_assert = 0, n_fail = 0;
    int ev[$];
    bit ed[$];
    int lv[$];

    always #5 clk = ~clk;

    dds_sweep_ctrl dut (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .phinc(phinc), .acc_clr(acc_clr), .busy(busy), .done(done), .dir(dir)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".phinc"}, 32'(phinc), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".dir"}, 32'(dir), 0);
    endtask

    // All values visited going from a to b, clamped at b.
    task automatic mk_leg(input int a, input int b, input int stp);
        int v;
        v = a;
        lv = {};
        lv.push_back(v);
        while (v != b) begin
            v = (v < b) ? ((v + stp > b) ? b : v + stp) : ((v - stp < b) ? b : v - stp);
            lv.push_back(v);
        end
    endtask

    task automatic expand(input int dw, input bit d);
        foreach (lv[i]) repeat (dw + 1) begin
            ev.push_back(lv[i]);
            ed.push_back(d);
        end
    endtask

    task automatic model(input int s, input int e, input int st, input int dw, input int md, input int len);
        int stp;
        stp = (st == 0) ? 1 : st;
        ev = {};
        ed = {};
        mk_leg(s, e, stp);
        expand(dw, 0);
        if (md == 1 || md == 2) while (ev.size() < len) begin
            if (md == 1) begin
                mk_leg(s, e, stp);
                expand(dw, 0);
            end else begin
                mk_leg(e, s, stp);
                if (lv.size() > 1) void'(lv.pop_front());
                expand(dw, 1);
                mk_leg(s, e, stp);
                if (lv.size() > 1) void'(lv.pop_front());
                expand(dw, 0);
            end
        end
    endtask

    // n_abort == 0: run a single sweep to its end; otherwise check n_abort cycles then abort.
    task automatic run(input int s, input int e, input int st, input int dw, input int md, input int n_abort);
        int n;
        model(s, e, st, dw, md, n_abort);
        n = (n_abort != 0) ? n_abort : ev.size();
        cfg_start = 8'(s); cfg_stop = 8'(e); cfg_step = 8'(st); cfg_dwell = 12'(dw); cfg_mode = 2'(md);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("phinc[%0d]", i), 32'(phinc), 32'(ev[i]));
            check($sformatf("dir[%0d]", i), 32'(dir), 32'(ed[i]));
            check($sformatf("busy[%0d]", i), 32'(busy), 1);
            check($sformatf("acc_clr[%0d]", i), 32'(acc_clr), (i == 0) ? 1 : 0);
            check($sformatf("done[%0d]", i), 32'(done), 0);
            start = (i == 1 && i < n - 1);
            cfg_start = 8'($urandom); cfg_stop = 8'($urandom); cfg_step = 8'($urandom);
            cfg_dwell = 12'($urandom_range(0, 7)); cfg_mode = 2'($urandom);
        end
        if (n_abort != 0) begin
            abort = 1'b1;
            start = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            check_idle("abort");
            @(negedge clk);
            check_idle("after_abort");
        end else begin
            @(negedge clk);
            start = 1'b0;
            check("fin.phinc", 32'(phinc), 0);
            check("fin.done", 32'(done), 1);
            check("fin.busy", 32'(busy), 0);
            @(negedge clk);
            check_idle("post_fin");
        end
    endtask

    initial begin
        #1;
        check_idle("reset");
        check("reset.acc_clr", 32'(acc_clr), 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        run(10, 40, 10, 2, 0, 0);
        run(10, 35, 10, 0, 0, 0);
        run(100, 80, 8, 0, 2, 20);
        run(250, 255, 10, 0, 0, 0);
        run(3, 5, 0, 1, 3, 0);
        run(10, 40, 10, 2, 0, 4);
        run(7, 7, 3, 1, 0, 0);
        run(7, 7, 3, 0, 2, 6);
        run(20, 60, 20, 1, 1, 16);
        cfg_start = 8'd10; cfg_stop = 8'd40; cfg_step = 8'd10; cfg_mode = 2'd0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");
        check("start_abort.acc_clr", 32'(acc_clr), 0);
        @(negedge clk);
        check_idle("start_abort2");
        cfg_start = 8'd5; cfg_stop = 8'd50; cfg_step = 8'd15; cfg_dwell = 12'd1; cfg_mode = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst.busy", 32'(busy), 1);
        #2 clrn = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("post_rst");
        run(30, 0, 12, 1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            int s, e, st, dw, md;
            s = $urandom_range(0, 255);
            e = $urandom_range(0, 255);
            st = $urandom_range(0, 40);
            dw = $urandom_range(0, 3);
            md = $urandom_range(0, 3);
            run(s, e, st, dw, md, (md == 1 || md == 2) ? $urandom_range(10, 60) : 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
